uart_rx: RTL and testbench

Host-facing UART receiver for the Hippomenes FPGA top. It deserialises the host's 8-bit asynchronous serial stream (LSB first, idle high) into bytes and buffers them in a small first-word-fall-through FIFO for the core's peripheral bus. It is the receive counterpart of the existing `tx` path and sits beside `top_arty` on the `clk_wiz_0` output clock. It reports framing, parity and overrun errors through sticky flags.

---
 rtl/uart_rx.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_uart_rx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: host-facing 8N1 / 8E1 UART receiver with a small first-word-fall-through
// receive FIFO and sticky framing / parity / overrun flags.
// Optional feature macro: UART_RX_PARITY_EN (adds an even-parity bit to each frame).
module uart_rx #(
    parameter int CLKS_PER_BIT = 174,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    input  logic       err_clr
);

    // Half-bit wait from the falling edge to the centre of the start bit.
    localparam int HALF = CLKS_PER_BIT / 2;
    // Counter width: holds values up to CLKS_PER_BIT-1.
    localparam int CW   = $clog2(CLKS_PER_BIT);
    // FIFO index width; pointers carry one extra wrap bit.
    localparam int PW   = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;
`endif

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic sync1_q;
    logic sync2_q;
    logic rxs;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    assign rxs = sync2_q;

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          push;
    logic          set_frame;
    logic          set_parity;

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;
    logic parity_ok;

    // Even parity: data bits plus parity bit must XOR to zero.
    assign parity_ok = ~(^{shift_q, par_q});
`endif

    // FSM state and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state logic; the bit-period counter free-runs and is cleared at every sample.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        bit_d      = bit_q;
        shift_d    = shift_q;
        push       = 1'b0;
        set_frame  = 1'b0;
        set_parity = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d      = par_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxs) begin
                    state_d = START;
                    bit_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    // A line that is high again mid-start-bit was only a glitch.
                    state_d = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxs, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    par_d   = rxs;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rxs) begin
                        // Leaving at mid-stop lets a back-to-back start bit be caught.
                        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (parity_ok) begin
                            push = 1'b1;
                        end else begin
                            set_parity = 1'b1;
                        end
`else
                        push = 1'b1;
`endif
                    end else begin
                        set_frame = 1'b1;
                        state_d   = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_d = '0;
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // First-word-fall-through FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [PW:0]   wr_q, wr_d;
    logic [PW:0]   rd_q, rd_d;
    logic [PW-1:0] wr_idx;
    logic [PW-1:0] rd_idx;
    logic          not_empty;
    logic          full;
    logic          pop;
    logic          push_ok;
    logic          ovr_set;

    assign wr_idx    = wr_q[PW-1:0];
    assign rd_idx    = rd_q[PW-1:0];
    assign not_empty = (wr_q != rd_q);
    assign full      = (wr_q[PW] != rd_q[PW]) && (wr_idx == rd_idx);
    assign pop       = not_empty && rx_ready;
    // A simultaneous pop frees the slot, so a push into a full FIFO still succeeds.
    assign push_ok   = push && (!full || pop);
    assign ovr_set   = push && !push_ok;

    // Per-entry next value: only the slot under the write pointer takes the new byte.
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_mem_next
            assign mem_d[gi] = (push_ok && (wr_idx == PW'(gi))) ? shift_q : mem_q[gi];
        end
    endgenerate

    // Pointer next values.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push_ok) begin
            wr_d = wr_q + 1'b1;
        end
        if (pop) begin
            rd_d = rd_q + 1'b1;
        end
    end

    // FIFO storage and pointers; storage is zeroed on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rx_valid = not_empty;
    assign rx_data  = not_empty ? mem_q[rd_idx] : 8'h00;

    // ------------------------------------------------------------------
    // Sticky error flags (a new error wins over a same-cycle clear)
    // ------------------------------------------------------------------
    logic ferr_q, ferr_d;
    logic ovr_q, ovr_d;

    // Sticky flag next values.
    always_comb begin
        ferr_d = set_frame | (ferr_q & ~err_clr);
        ovr_d  = ovr_set   | (ovr_q  & ~err_clr);
    end

    // Sticky flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            ferr_q <= ferr_d;
            ovr_q  <= ovr_d;
        end
    end

    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

`ifdef UART_RX_PARITY_EN
    logic perr_q, perr_d;

    // Parity flag next value.
    always_comb begin
        perr_d = set_parity | (perr_q & ~err_clr);
    end

    // Parity flag register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign parity_err = perr_q;
`else
    // Without a parity bit in the frame, a parity error cannot happen.
    assign parity_err = 1'b0;

    logic unused_ok;
    assign unused_ok = set_parity;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: frame-level reference model plus per-cycle output checks.
module tb_uart_rx;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;
    localparam int H     = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NB  = 10;
    localparam bit PAR = 1'b1;
`else
    localparam int NB  = 9;
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b1;
    logic       err_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;

    uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        bit         stop_ok;
        bit         par_ok;
    } ev_t;

    ev_t        evq[$];
    logic [7:0] mq[$];
    logic [7:0] popped[$];
    bit         mf = 1'b0;
    bit         mp = 1'b0;
    bit         mo = 1'b0;
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame outcomes land on their stop-sample edge.
    always @(posedge clk) begin : model
        bit         do_pop;
        bit         is_full;
        bit         fs;
        bit         ps;
        bit         os;
        bit         do_push;
        logic [7:0] pd;
        ev_t        ev;
        cyc++;
        if (reset) begin
            mq.delete();
            evq.delete();
            mf = 1'b0;
            mp = 1'b0;
            mo = 1'b0;
        end else begin
            do_pop  = (mq.size() > 0) && rx_ready;
            is_full = (mq.size() == DEPTH);
            fs = 1'b0; ps = 1'b0; os = 1'b0; do_push = 1'b0; pd = 8'h00;
            if (evq.size() > 0 && evq[0].cyc == cyc) begin
                ev = evq.pop_front();
                if (!ev.stop_ok)     fs = 1'b1;
                else if (!ev.par_ok) ps = 1'b1;
                else begin
                    do_push = 1'b1;
                    pd      = ev.data;
                end
            end
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                if (!is_full || do_pop) mq.push_back(pd);
                else os = 1'b1;
            end
            mf = fs | (mf & !err_clr);
            mp = ps | (mp & !err_clr);
            mo = os | (mo & !err_clr);
        end
    end

    // Compare DUT against the model every cycle, and record consumed bytes.
    always @(negedge clk) begin
        if (reset) begin
            chk("reset_valid", rx_valid, 0);
            chk("reset_data", rx_data, 0);
            chk("reset_frame_err", frame_err, 0);
            chk("reset_parity_err", parity_err, 0);
            chk("reset_overrun", overrun, 0);
        end else begin
            chk("rx_valid", rx_valid, (mq.size() > 0));
            if (mq.size() > 0) chk("rx_data", rx_data, mq[0]);
            chk("frame_err", frame_err, mf);
            chk("parity_err", parity_err, mp);
            chk("overrun", overrun, mo);
            if (rx_valid && rx_ready) begin
                popped.push_back(rx_data);
                $display("pop  %02h at %0t", rx_data, $time);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input logic [7:0] d, input bit bad_par, input bit stop);
        ev_t ev;
        ev.cyc     = cyc + 3 + H + NB * CPB;
        ev.data    = d;
        ev.stop_ok = stop;
        ev.par_ok  = !(bad_par && PAR);
        evq.push_back(ev);
        $display("send %02h bad_par=%0d stop=%0d at %0t", d, bad_par, stop, $time);
        rx = 1'b0;
        step(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            step(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ bad_par;
        step(CPB);
`endif
        rx = stop;
        step(CPB);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        step(2);
    endtask

    initial begin
        logic [7:0] f0;
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        step(5);

        // Back-to-back frames with the consumer always ready.
        send(8'h55, 1'b0, 1'b1);
        send(8'hA3, 1'b0, 1'b1);
        step(20);
        chk("t1_count", popped.size(), 2);
        if (popped.size() == 2) begin
            chk("t1_byte0", popped[0], 8'h55);
            chk("t1_byte1", popped[1], 8'hA3);
        end
        chk("t1_frame_err", frame_err, 0);
        chk("t1_overrun", overrun, 0);
        popped.delete();

        // Short low glitch on an idle line.
        rx = 1'b0;
        step(3);
        rx = 1'b1;
        step(3 * CPB);
        chk("t2_count", popped.size(), 0);
        chk("t2_valid", rx_valid, 0);
        chk("t2_frame_err", frame_err, 0);

        // Bad stop bit followed by a held-low line, then a good frame.
        send(8'h3C, 1'b0, 1'b0);
        step(40);
        rx = 1'b1;
        step(2 * CPB);
        chk("t3_frame_err_set", frame_err, 1);
        chk("t3_model_frame_err", mf, 1);
        send(8'h81, 1'b0, 1'b1);
        step(20);
        chk("t3_count", popped.size(), 1);
        if (popped.size() == 1) chk("t3_byte0", popped[0], 8'h81);
        pulse_clr();
        chk("t3_frame_err_clr", frame_err, 0);
        popped.delete();

        // Overrun with the consumer stalled.
        rx_ready = 1'b0;
        for (int v = 1; v <= 5; v++) send(8'(v), 1'b0, 1'b1);
        step(2);
        chk("t4_overrun_set", overrun, 1);
        chk("t4_model_overrun", mo, 1);
        chk("t4_valid", rx_valid, 1);
        chk("t4_head", rx_data, 8'h01);
        rx_ready = 1'b1;
        step(10);
        chk("t4_count", popped.size(), 4);
        if (popped.size() == 4) begin
            chk("t4_byte0", popped[0], 8'h01);
            chk("t4_byte1", popped[1], 8'h02);
            chk("t4_byte2", popped[2], 8'h03);
            chk("t4_byte3", popped[3], 8'h04);
        end
        chk("t4_empty", rx_valid, 0);
        pulse_clr();
        chk("t4_overrun_clr", overrun, 0);
        popped.delete();

`ifdef UART_RX_PARITY_EN
        // Wrong parity bit, then correct parity bit.
        send(8'h07, 1'b1, 1'b1);
        step(20);
        chk("t5_parity_err_set", parity_err, 1);
        chk("t5_count_bad", popped.size(), 0);
        send(8'h07, 1'b0, 1'b1);
        step(20);
        chk("t5_count_good", popped.size(), 1);
        if (popped.size() == 1) chk("t5_byte0", popped[0], 8'h07);
        pulse_clr();
        chk("t5_parity_err_clr", parity_err, 0);
        popped.delete();
`endif

        // Reset in the middle of data bit 4 of 0xF0.
        f0 = 8'hF0;
        rx = 1'b0;
        step(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = f0[i];
            step(CPB);
        end
        rx = f0[4];
        step(3);
        reset = 1'b1;
        step(1);
        chk("t6_reset_valid", rx_valid, 0);
        chk("t6_reset_data", rx_data, 0);
        chk("t6_reset_flags", {frame_err, parity_err, overrun}, 0);
        rx = 1'b1;
        step(4);
        reset = 1'b0;
        step(2 * CPB);
        chk("t6_idle_valid", rx_valid, 0);
        send(8'h5A, 1'b0, 1'b1);
        step(20);
        chk("t6_count", popped.size(), 1);
        if (popped.size() == 1) chk("t6_byte0", popped[0], 8'h5A);
        chk("t6_frame_err", frame_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
